// File: rtl/hdlc_tx_sequencer.sv
// hdlc_tx_sequencer: bit-serial HDLC transmit sequencer. Emits an opening
// flag, the buffered payload LSB-first with zero insertion, an optional FCS
// and a closing flag; produces the abort pattern on request and idle ones
// otherwise.
// Optional feature macro: HDLC_TX_FCS_EN (CRC-16/X.25 FCS field).
module hdlc_tx_sequencer #(
    parameter int FRAME_MAX = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_FrameSize,
    input  logic [7:0] Tx_DataOutBuff,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans
);

    localparam logic [7:0] FrameMax = 8'(FRAME_MAX);
    localparam logic [7:0] FlagByte = 8'h7E;

`ifdef HDLC_TX_FCS_EN
    typedef enum logic [2:0] {IDLE, FLAG_START, DATA, FCS, FLAG_END, ABORT} seqState_t;
`else
    typedef enum logic [2:0] {IDLE, FLAG_START, DATA, FLAG_END, ABORT} seqState_t;
`endif

    seqState_t  state, stateNext;
    logic [3:0] bitCnt, bitCntNext;
    logic [7:0] shiftReg, shiftNext;
    logic [7:0] prefetch, prefetchNext;
    logic       fetchPending;
    logic [7:0] bytesLeft, bytesLeftNext;
    logic [2:0] onesCnt, onesNext;
    logic       donePend, donePendNext;
    logic       txNext, validNext, doneNext, abortedNext;
    logic       rdBuff;
    logic       stuffNow;
    logic       dataBit;

`ifdef HDLC_TX_FCS_EN
    logic [15:0] crc, crcNext;

    // One step of the reflected CRC-16/X.25 (polynomial 0x8408).
    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
    endfunction
`endif

    assign Tx_RdBuff = rdBuff;
    assign stuffNow  = (onesCnt == 3'd5);

    // Next-state, next-bit and buffer-strobe logic; the serial outputs are
    // registered one cycle later so Tx never glitches.
    always_comb begin
        stateNext     = state;
        bitCntNext    = bitCnt;
        shiftNext     = shiftReg;
        prefetchNext  = fetchPending ? Tx_DataOutBuff : prefetch;
        bytesLeftNext = bytesLeft;
        onesNext      = onesCnt;
        donePendNext  = 1'b0;
        txNext        = 1'b1;
        validNext     = 1'b0;
        doneNext      = 1'b0;
        abortedNext   = Tx_AbortedTrans;
        rdBuff        = 1'b0;
        dataBit       = 1'b0;
`ifdef HDLC_TX_FCS_EN
        crcNext       = crc;
`endif

        if (state == IDLE) begin
            doneNext = donePend;
            if (Tx_Enable && (Tx_FrameSize != 8'd0) && (Tx_FrameSize <= FrameMax)) begin
                stateNext     = FLAG_START;
                bitCntNext    = 4'd0;
                bytesLeftNext = Tx_FrameSize;
                onesNext      = 3'd0;
                abortedNext   = 1'b0;
`ifdef HDLC_TX_FCS_EN
                crcNext       = 16'hFFFF;
`endif
            end
        end else if ((state != ABORT) && Tx_AbortFrame) begin
            stateNext   = ABORT;
            bitCntNext  = 4'd1;
            txNext      = 1'b0;
            validNext   = 1'b1;
            abortedNext = 1'b1;
        end else begin
            validNext = 1'b1;
            case (state)
                FLAG_START: begin
                    txNext = FlagByte[bitCnt[2:0]];
                    if (bitCnt == 4'd0) begin
                        rdBuff = 1'b1;
                    end
                    if (bitCnt == 4'd7) begin
                        shiftNext     = prefetch;
                        bytesLeftNext = bytesLeft - 8'd1;
                        rdBuff        = (bytesLeft > 8'd1);
                        stateNext     = DATA;
                        bitCntNext    = 4'd0;
                    end else begin
                        bitCntNext = bitCnt + 4'd1;
                    end
                end
                DATA: begin
                    if (stuffNow) begin
                        txNext   = 1'b0;
                        onesNext = 3'd0;
                    end else begin
                        dataBit   = shiftReg[0];
                        txNext    = dataBit;
                        onesNext  = dataBit ? onesCnt + 3'd1 : 3'd0;
                        shiftNext = {1'b0, shiftReg[7:1]};
`ifdef HDLC_TX_FCS_EN
                        crcNext   = crcStep(crc, dataBit);
`endif
                        if (bitCnt == 4'd7) begin
                            bitCntNext = 4'd0;
                            if (bytesLeft != 8'd0) begin
                                shiftNext     = prefetch;
                                bytesLeftNext = bytesLeft - 8'd1;
                                rdBuff        = (bytesLeft > 8'd1);
                            end else begin
`ifdef HDLC_TX_FCS_EN
                                stateNext = FCS;
`else
                                stateNext = FLAG_END;
`endif
                            end
                        end else begin
                            bitCntNext = bitCnt + 4'd1;
                        end
                    end
                end
`ifdef HDLC_TX_FCS_EN
                FCS: begin
                    if (stuffNow) begin
                        txNext   = 1'b0;
                        onesNext = 3'd0;
                    end else begin
                        dataBit  = ~crc[0];
                        txNext   = dataBit;
                        onesNext = dataBit ? onesCnt + 3'd1 : 3'd0;
                        crcNext  = {1'b0, crc[15:1]};
                        if (bitCnt == 4'd15) begin
                            stateNext  = FLAG_END;
                            bitCntNext = 4'd0;
                        end else begin
                            bitCntNext = bitCnt + 4'd1;
                        end
                    end
                end
`endif
                FLAG_END: begin
                    onesNext = 3'd0;
                    if (stuffNow) begin
                        txNext = 1'b0;
                    end else begin
                        txNext = FlagByte[bitCnt[2:0]];
                        if (bitCnt == 4'd7) begin
                            stateNext    = IDLE;
                            bitCntNext   = 4'd0;
                            donePendNext = 1'b1;
                        end else begin
                            bitCntNext = bitCnt + 4'd1;
                        end
                    end
                end
                ABORT: begin
                    txNext = 1'b1;
                    if (bitCnt == 4'd7) begin
                        stateNext  = IDLE;
                        bitCntNext = 4'd0;
                    end else begin
                        bitCntNext = bitCnt + 4'd1;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    validNext = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered serial outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state           <= IDLE;
            bitCnt          <= 4'd0;
            shiftReg        <= 8'd0;
            prefetch        <= 8'd0;
            fetchPending    <= 1'b0;
            bytesLeft       <= 8'd0;
            onesCnt         <= 3'd0;
            donePend        <= 1'b0;
            Tx              <= 1'b1;
            Tx_ValidFrame   <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
        end else begin
            state           <= stateNext;
            bitCnt          <= bitCntNext;
            shiftReg        <= shiftNext;
            prefetch        <= prefetchNext;
            fetchPending    <= rdBuff;
            bytesLeft       <= bytesLeftNext;
            onesCnt         <= onesNext;
            donePend        <= donePendNext;
            Tx              <= txNext;
            Tx_ValidFrame   <= validNext;
            Tx_Done         <= doneNext;
            Tx_AbortedTrans <= abortedNext;
        end
    end

`ifdef HDLC_TX_FCS_EN
    // Running CRC over unstuffed payload bits, then shifted out as the FCS.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            crc <= 16'hFFFF;
        end else begin
            crc <= crcNext;
        end
    end
`endif

endmodule
